// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
// Imported by the picker and the arbiter top.
package arb_pkg;

  localparam int NUM_REQ   = 8;
  localparam int REQ_IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Rotating-priority pick: first set req bit at or above ptr,
// wrapping from 7 to 0. Purely combinational.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic                 found,
  output logic [REQ_IDX_W-1:0] idx
);

  logic [NUM_REQ-1:0]   rot;
  logic [REQ_IDX_W-1:0] off;

  assign rot = NUM_REQ'({req, req} >> ptr);

  // lowest set bit of the rotated vector wins
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = REQ_IDX_W'(i);
    end
  end

  assign found = |req;
  assign idx   = off + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a hold-limit timer.
// Grants are registered; one idle cycle separates any two grants.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [REQ_IDX_W-1:0] gnt_id,
  output logic                 busy
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

  arb_state_t           state;
  logic [REQ_IDX_W-1:0] ptr;
  logic [CW-1:0]        hold_cnt;
  logic                 found;
  logic [REQ_IDX_W-1:0] pick;
  logic                 rel;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  // owner dropped its request or used up its hold budget
  assign rel = !req[gnt_id] || (hold_cnt == LAST);

  // arbitration FSM with registered grant outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt      <= NUM_REQ'(1) << pick;
            gnt_id   <= pick;
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            ptr    <= gnt_id + REQ_IDX_W'(1);
            state  <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource between 8 requesters, such as the 8:3 encode path or a shared output port. Each cycle with no active grant, it picks one requester with a rotating-priority search, which is an 8-input priority encode with a moving start point. It holds the grant until the owner releases or a hold-limit timer expires. Outputs are registered one-hot and binary grants for the resource mux and the status logic.

## Interface

Parameters:
- MAX_HOLD, default 16: maximum consecutive grant cycles per owner.
  - Legal range is 2..256.
  - Counter width is $clog2(MAX_HOLD).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  8  request per requester; hold high for as long as the resource is needed.
- gnt  out  8  registered one-hot grant; all zeros when idle.
- gnt_id  out  3  registered binary index of the owner; 0 when idle.
- busy  out  1  high while any grant is active.

## Operation

Reset values:
- gnt = 8'h00, gnt_id = 3'd0, busy = 0.
- Internal: ptr = 3'd0, hold_cnt = 0, state = IDLE.

State machine, two states:
- IDLE
  - If req != 0: search req starting at index ptr, upward, wrapping from 7 to 0.
  - The first set bit g wins: gnt <= 1<<g, gnt_id <= g, busy <= 1, hold_cnt <= 0, go to GRANT.
  - If req == 0: stay in IDLE with all outputs at 0.
- GRANT
  - Release: req[gnt_id] == 0.
  - Timeout: hold_cnt == MAX_HOLD-1.
  - On release or timeout: gnt <= 0, gnt_id <= 0, busy <= 0, ptr <= gnt_id+1 (mod 8), go to IDLE.
  - Otherwise: hold_cnt increments and the grant is unchanged.

Boundary conditions:
- Release and timeout on the same edge are handled as one release; ptr is updated once.
- req bits other than the owner's are ignored during GRANT. No preemption except timeout.
- ptr wrap: after owner 7, the search starts at 0.
- A single persistent requester is re-granted after the one-cycle gap. Its grant duty cycle is MAX_HOLD of every MAX_HOLD+1 cycles.
- A req pulse that is low at the IDLE edge is not granted. Requests are not latched.
- rst high mid-grant: outputs are 0 after that edge and ptr returns to 0, regardless of req.
- gnt is always zero or one-hot, and busy == |gnt. Both are checked as invariants.

## Timing

- Grant latency: req sampled high at edge N in IDLE gives gnt visible after edge N (cycle N+1).
- Release latency: req[owner] low at edge M drops gnt after edge M. There is no combinational path from req to gnt.
- Minimum turnaround is one idle cycle with gnt = 0 between any two grants, including to the same requester.
- Maximum grant length is MAX_HOLD cycles.
- Worst-case wait for a requester holding req high:
  - 7 × (MAX_HOLD+1) cycles for the other owners, plus one arbitration cycle.

## Structure

- Shared package arb_pkg holds:
  - NUM_REQ = 8 and REQ_IDX_W = 3.
  - The state enum arb_state_t {IDLE, GRANT}.
- Sub-module rr_pick8 is purely combinational.
  - Inputs: req[7:0] and ptr[2:0].
  - Outputs: found, idx[2:0].
  - Implementation: rotate req right by ptr, apply a lowest-index-wins priority encode, then add ptr back mod 8.
- The top level holds the state register, ptr, hold_cnt and the output registers.

## Test plan

- Reset/idle: rst for 2 cycles, req=8'h00 for 5 cycles -> gnt=0, gnt_id=0, busy=0 throughout.
- Single request: req=8'h80 from cycle 3 to cycle 7, then 0.
  - gnt=8'h80 and gnt_id=7 from cycle 4 to cycle 8.
  - busy drops in cycle 9.
  - The next search starts at 0.
- Round-robin order: req=8'hFF held, MAX_HOLD=4.
  - Grant order 0,1,2,...,7,0.
  - Each grant lasts 4 cycles, separated by a 1-cycle gnt=0 gap.
- Contention after release: owner 2 drops req while req=8'h21 (bits 0 and 5).
  - After the gap, 5 is granted, since ptr=3.
  - When 5 releases, 0 is granted.
- Timeout with a simultaneous release edge: owner 3 drops req on the same edge that hold_cnt reaches MAX_HOLD-1.
  - Exactly one release, and ptr=4.
  - Assert gnt is one-hot or zero every cycle.
- Reset mid-grant: rst=1 while gnt=8'h10 with req=8'h11.
  - gnt=0 after the edge.
  - After rst drops, bit 0 is granted (ptr back to 0).
